// File: rtl/alu_pkg.sv
// Shared definitions for alu_mdu: op encoding, FSM states, iterative-unit mode.
// Latency: none (package only).
// Backpressure: none (package only).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mdu_mode_e;

    function automatic logic is_mul(alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div(alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative N-step datapath: unsigned shift-add multiply or restoring divide.
// Latency: N cycles after start; done pulses alongside the final step.
// Backpressure: none; the owner must not pulse start while an operation iterates.
//
// Ports: clk, reset (async active-high), start (load a/b, begin), mode,
//        a/b (unsigned operands), done (final step this cycle),
//        hi/lo (next-state accumulator/shift register: product hi/lo or
//        remainder/quotient; valid on done and held afterwards).
module mdu_iter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  mdu_mode_e    mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N);

    logic          active_q;
    mdu_mode_e     mode_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  sr_q;
    logic [N-1:0]  opb_q;
    logic [N-1:0]  acc_d;
    logic [N-1:0]  sr_d;

    // Multiply step: conditionally add multiplicand, then shift {carry,acc,sr} right.
    logic [N:0]    mul_sum;
    // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
    logic [N:0]    shifted;
    logic          fits;
    logic [N-1:0]  rem_sub;

    assign mul_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
    assign shifted = {acc_q, sr_q[N-1]};
    assign fits    = shifted >= {1'b0, opb_q};
    assign rem_sub = N'(shifted - {1'b0, opb_q});

    always_comb begin
        acc_d = acc_q;
        sr_d  = sr_q;
        if (start) begin
            acc_d = '0;
            sr_d  = a;
        end else if (active_q) begin
            if (mode_q == MODE_MUL) begin
                acc_d = mul_sum[N:1];
                sr_d  = {mul_sum[0], sr_q[N-1:1]};
            end else begin
                acc_d = fits ? rem_sub : shifted[N-1:0];
                sr_d  = {sr_q[N-2:0], fits};
            end
        end
    end

    assign done = active_q && (cnt_q == CW'(N - 1));
    assign hi   = acc_d;
    assign lo   = sr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            mode_q   <= MODE_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            sr_q     <= '0;
            opb_q    <= '0;
        end else begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            if (start) begin
                active_q <= 1'b1;
                mode_q   <= mode;
                cnt_q    <= '0;
                opb_q    <= b;
            end else if (active_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (done) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU plus iterative RV32M multiply/divide subset, one op in flight.
// Latency: 1 cycle for ALU ops and divide special cases, N+1 for MUL/MULHU, N+2 for divides.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
//
// Ports: clk, reset (async active-high), in_valid/in_ready/op/a/b (request),
//        out_valid/out_ready/result/zero_flag (registered response),
//        busy (multi-cycle op iterating or being sign-corrected).
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int N   = 32,
    localparam int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero_flag,
    output logic         busy
);

    state_e       state_q;
    state_e       state_d;
    alu_op_e      op_e;
    alu_op_e      op_q;
    logic         q_neg_q;
    logic         r_neg_q;
    logic [N-1:0] result_q;
    logic         zero_q;

    logic         accept;
    logic         signed_div;
    logic         a_neg;
    logic         b_neg;
    logic [N-1:0] a_mag;
    logic [N-1:0] b_mag;
    logic         div_zero;
    logic         div_ovf;
    logic [N-1:0] alu_res;
    logic [N-1:0] special_res;
    logic [SHW-1:0] shamt;

    logic         load_res;
    logic [N-1:0] res_d;
    logic         iter_start;
    mdu_mode_e    iter_mode;
    logic         iter_done;
    logic [N-1:0] iter_hi;
    logic [N-1:0] iter_lo;

    assign op_e       = alu_op_e'(op);
    assign accept     = in_valid && (state_q == ST_IDLE);
    assign signed_div = (op_e == OP_DIV) || (op_e == OP_REM);
    assign a_neg      = signed_div && a[N-1];
    assign b_neg      = signed_div && b[N-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;
    assign div_zero   = (b == '0);
    assign div_ovf    = signed_div && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
    assign shamt      = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op_e)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, a < b};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Quotient ops: all ones on /0, a on overflow. Remainder ops: a on /0, 0 on overflow.
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? '1 : a;
        end else if (div_ovf) begin
            special_res = (op_e == OP_DIV) ? a : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_res   = 1'b0;
        res_d      = '0;
        iter_start = 1'b0;
        iter_mode  = MODE_MUL;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul(op_e)) begin
                        iter_start = 1'b1;
                        iter_mode  = MODE_MUL;
                        state_d    = ST_MUL;
                    end else if (is_div(op_e) && !div_zero && !div_ovf) begin
                        iter_start = 1'b1;
                        iter_mode  = MODE_DIV;
                        state_d    = ST_DIV;
                    end else begin
                        load_res = 1'b1;
                        res_d    = is_div(op_e) ? special_res : alu_res;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (iter_done) begin
                    load_res = 1'b1;
                    res_d    = (op_q == OP_MUL) ? iter_lo : iter_hi;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                if (iter_done) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Iterator now holds unsigned quotient (lo) and remainder (hi).
                load_res = 1'b1;
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                    res_d = q_neg_q ? -iter_lo : iter_lo;
                end else begin
                    res_d = r_neg_q ? -iter_hi : iter_hi;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_e;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
            end
            if (load_res) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
            end
        end
    end

    mdu_iter #(.N(N)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (iter_start),
        .mode  (iter_mode),
        .a     (a_mag),
        .b     (b_mag),
        .done  (iter_done),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
    assign result    = result_q;
    assign zero_flag = zero_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the processor's single-cycle ALU. Adds a full RV32I integer op set plus an iterative multiply/divide unit (RV32M subset) behind a valid/ready handshake, so the pipeline's EX stage can stall on long ops. One operation is in flight at a time. The result is registered and held until the consumer accepts it. zero_flag is asserted exactly when the result is zero.

Parameters:
N, 32, operand/result width in bits (even, >= 8)
SHW, $clog2(N), shift-amount width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  4  operation code (alu_pkg encoding)
a  input  N  operand A
b  input  N  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  N  registered result
zero_flag  output  1  result == 0, registered with result
busy  output  1  multi-cycle op iterating

Behaviour:
- Reset (async, active-high) values: state=IDLE, in_ready=1, out_valid=0, result=0, zero_flag=0, busy=0. Reset mid-operation aborts the op and discards its operands and partial result. The first accept is possible on the first clock edge after reset deasserts.
- Accept: the request is accepted when in_valid && in_ready on a clock edge. a, b and op are captured at accept; later input changes are ignored.
- in_ready = (state==IDLE). There is no new accept while iterating or while holding a result.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> DONE for single-cycle ops and for divide special cases. out_valid rises 1 cycle after accept.
- IDLE -> MUL for MUL and MULHU: N shift-add iterations, then DONE. out_valid rises at cycle N+1 after accept.
- IDLE -> DIV for DIV, DIVU, REM and REMU: N restoring-division iterations on magnitudes, then FIX for one cycle (sign correction), then DONE. out_valid rises at cycle N+2 after accept.
- DONE: out_valid=1, and result and zero_flag are held stable. On out_ready=1 the unit goes DONE -> IDLE, and in_ready=1 the next cycle. There is no same-cycle turnaround.
- busy=1 in MUL, DIV and FIX only.
- Single-cycle ops:
  - ADD and SUB wrap modulo 2^N.
  - SLT is signed and SLTU is unsigned; each returns 0 or 1, zero-extended.
  - SLL, SRL and SRA use b[SHW-1:0]; the upper bits of b are ignored. SRA sign-fills.
- MUL returns the low N bits of a*b. MULHU returns the high N bits of the unsigned 2N-bit product.
- DIV/REM are signed and truncate toward zero. The remainder takes the dividend's sign.
- Divide special cases, all resolved in the accept cycle (fast path, out_valid at cycle 1):
  - Divide by zero: quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative value, b = -1): quotient = a; remainder = 0.

Decomposition:
- alu_pkg holds the op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL
  - 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU
- alu_pkg also holds the state encoding, plus helper functions is_mul(op) and is_div(op).
- One sub-module, mdu_iter: an N-bit iterative datapath holding the accumulator/remainder, multiplier/quotient shift register and iteration counter. It takes a start pulse and a mode (mul or div) and returns a done pulse. The top level owns the FSM, the single-cycle ops, special cases, sign fixup and output registers.

Test Plan:
- ALU ops, N=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, zero_flag 0, out_valid 1 cycle after accept.
  - SUB 5-5 -> 0, zero_flag 1.
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU with the same operands -> 0.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and MULHU with the same operands -> 0xFFFFFFFE, each with out_valid at cycle 33 and busy=1 for cycles 1..32.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, out_valid at cycle 34. DIVU 100/7 -> 14 and REMU 100/7 -> 2.
- Special cases, all with out_valid at cycle 1:
  - DIVU 0x1234/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and zero_flag stable, in_ready=0, a concurrent in_valid is not accepted. On out_ready=1 -> in_ready=1 the next cycle.
- Reset mid-operation: assert reset during iteration 10 of DIVU -> out_valid=0, busy=0, in_ready=1 immediately. After deassert, ADD 3+4 -> 7 with normal 1-cycle latency.
